uart_tx_buffered: RTL and testbench

//   Parametrised UART transmitter that supersedes uart_transmitter. Adds a write FIFO,

---
 rtl/uart_tx_buffered.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter. Words written through a FIFO are serialised
//   LSB first as: start bit, DATA_BITS data bits, optional parity bit,
//   STOP_BITS stop bits. The line only changes on clk edges where
//   tx_baud_tick is high, so each level lasts exactly one tick interval.
//   Queued frames go out back-to-back while tx_enable stays high.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset; aborts any frame, flushes FIFO
//   tx_baud_tick  one-clk pulse per bit period
//   tx_data       write data (sampled only when the write is accepted)
//   tx_valid      write request
//   tx_ready      FIFO not full
//   tx_enable     1 = frames may start, 0 = hold the queue
//   tx_pin        registered serial line, idle high
//   tx_busy       frame in progress
//   fifo_count    words queued, 0..FIFO_DEPTH
//
// state | meaning
// IDLE  | line high, waiting for a tick with data queued and tx_enable set
// START | start bit (low) on the line
// DATA  | data bits on the line, LSB first
// PAR   | parity bit on the line
// STOP  | stop bit(s) on the line; may chain straight into the next START

module uart_tx_buffered #(
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY     = 0,
  parameter  int STOP_BITS  = 1,
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 tx_enable,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic [AW:0]          fifo_count
);

  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  state_t               r_state,    w_state_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic                 r_parity,   w_parity_nxt;
  logic [BW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_tx_pin,   w_tx_pin_nxt;

  logic                 w_wr;
  logic                 w_pop;
  logic                 w_can_start;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_parity;

  // tx_ready depends only on the registered count, so a pop in the same
  // cycle never lets a write into a full FIFO.
  assign tx_ready      = (r_count != (AW+1)'(FIFO_DEPTH));
  assign w_wr          = tx_valid && tx_ready;
  assign w_can_start   = (r_count != '0) && tx_enable;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_parity = (PARITY == 2) ? ~^w_head : ^w_head;

  assign tx_pin     = r_tx_pin;
  assign tx_busy    = (r_state != IDLE);
  assign fifo_count = r_count;

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx_pin   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx_pin   <= w_tx_pin_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_pin_nxt   = r_tx_pin;
    w_pop          = 1'b0;

    if (tx_baud_tick) begin
      case (r_state)
        IDLE: begin
          w_tx_pin_nxt = 1'b1;
          if (w_can_start) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_head;
            w_parity_nxt = w_head_parity;
            w_tx_pin_nxt = 1'b0;
            w_state_nxt  = START;
          end
        end
        START: begin
          w_tx_pin_nxt  = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end
        DATA: begin
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              w_tx_pin_nxt = r_parity;
              w_state_nxt  = PAR;
            end else begin
              w_tx_pin_nxt   = 1'b1;
              w_stop_cnt_nxt = 1'b0;
              w_state_nxt    = STOP;
            end
          end else begin
            w_tx_pin_nxt  = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
        PAR: begin
          w_tx_pin_nxt   = 1'b1;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = STOP;
        end
        STOP: begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            if (w_can_start) begin
              // chain directly into the next frame, no idle bit between
              w_pop        = 1'b1;
              w_shift_nxt  = w_head;
              w_parity_nxt = w_head_parity;
              w_tx_pin_nxt = 1'b0;
              w_state_nxt  = START;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
        default: begin
          w_tx_pin_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Three transmitters (8N1, 8E2, 8O2) share one stimulus stream. A
// frame-level model per instance predicts line level, busy, count and ready.
module tb_uart_tx_buffered;

  localparam int DEPTH = 16;
  localparam int NDUT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_baud_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_enable = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic [NDUT-1:0] w_pin, w_busy, w_ready;
  logic [4:0]      w_cnt [NDUT];

  always #5 clk = ~clk;

  uart_tx_buffered #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_baud_tick(tx_baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(w_ready[0]), .tx_enable(tx_enable),
    .tx_pin(w_pin[0]), .tx_busy(w_busy[0]), .fifo_count(w_cnt[0]));

  uart_tx_buffered #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_baud_tick(tx_baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(w_ready[1]), .tx_enable(tx_enable),
    .tx_pin(w_pin[1]), .tx_busy(w_busy[1]), .fifo_count(w_cnt[1]));

  uart_tx_buffered #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_baud_tick(tx_baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(w_ready[2]), .tx_enable(tx_enable),
    .tx_pin(w_pin[2]), .tx_busy(w_busy[2]), .fifo_count(w_cnt[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instance k: parity mode k (0 none, 1 even, 2 odd); stop bits 1 for k=0, else 2.
  function automatic int par_mode(int k);
    return k;
  endfunction

  function automatic int stop_bits(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Model: queued words, and the remaining line levels of the frame in
  // flight (element 0 is the level currently on the line).
  int mq [NDUT][$];
  bit mb [NDUT][$];
  int         m_osz;
  bit         m_acc;
  logic [7:0] m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NDUT; k++) begin
        mq[k].delete();
        mb[k].delete();
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        m_osz = mq[k].size();
        m_acc = tx_valid && (m_osz != DEPTH);
        if (tx_baud_tick) begin
          if (mb[k].size() != 0) void'(mb[k].pop_front());
          if (mb[k].size() == 0 && m_osz != 0 && tx_enable) begin
            m_w = 8'(mq[k].pop_front());
            mb[k].push_back(1'b0);
            for (int i = 0; i < 8; i++) mb[k].push_back(m_w[i]);
            if (par_mode(k) == 1) mb[k].push_back(^m_w);
            if (par_mode(k) == 2) mb[k].push_back(~^m_w);
            for (int s = 0; s < stop_bits(k); s++) mb[k].push_back(1'b1);
          end
        end
        if (m_acc) mq[k].push_back(int'(tx_data));
      end
    end
  end

  function automatic logic exp_pin(int k);
    return (mb[k].size() != 0) ? mb[k][0] : 1'b1;
  endfunction

  function automatic bit model_idle(bit need_empty_q);
    for (int k = 0; k < NDUT; k++) begin
      if (mb[k].size() != 0) return 1'b0;
      if (need_empty_q && mq[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  bit chk_on = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_on) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("pin%0d", k),   32'(w_pin[k]),   32'(exp_pin(k)));
        check($sformatf("busy%0d", k),  32'(w_busy[k]),  32'(mb[k].size() != 0));
        check($sformatf("count%0d", k), 32'(w_cnt[k]),   32'(mq[k].size()));
        check($sformatf("ready%0d", k), 32'(w_ready[k]), 32'(mq[k].size() != DEPTH));
      end
    end
  end

  bit tick_auto = 1'b1;
  int tgap = 0;

  always @(negedge clk) begin
    if (tick_auto) begin
      if (tgap == 0) begin
        tx_baud_tick = 1'b1;
        tgap = int'($urandom_range(1, 4));
      end else begin
        tx_baud_tick = 1'b0;
        tgap--;
      end
    end
  end

  task automatic write_word(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit need_empty_q, input string tag);
    int n = 0;
    while (!model_idle(need_empty_q) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_bits_left(input int left, input string tag);
    int n = 0;
    while (mb[0].size() != left && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_pin%0d", k),   32'(w_pin[k]),   32'd1);
      check($sformatf("rst_busy%0d", k),  32'(w_busy[k]),  32'd0);
      check($sformatf("rst_ready%0d", k), 32'(w_ready[k]), 32'd1);
      check($sformatf("rst_count%0d", k), 32'(w_cnt[k]),   32'd0);
    end

    // single words: 0x55 then 0xA3 (even parity 0, odd parity 1)
    tx_enable = 1'b1;
    write_word(8'h55);
    wait_idle(3000, 1'b1, "w55");
    write_word(8'hA3);
    wait_idle(3000, 1'b1, "wA3");

    // fill to full while held, one refused write, then drain back-to-back
    tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) write_word(8'(i));
    check("full_count", 32'(w_cnt[0]), 32'd16);
    check("full_ready", 32'(w_ready[0]), 32'd0);
    write_word(8'hEE);
    check("refused_count", 32'(w_cnt[0]), 32'd16);
    tx_enable = 1'b1;
    wait_idle(20000, 1'b1, "drain16");

    // drop enable during DATA of frame 1 of 3
    write_word(8'($urandom));
    write_word(8'($urandom));
    write_word(8'($urandom));
    wait_bits_left(6, "mid_data");
    tx_enable = 1'b0;
    wait_idle(3000, 1'b0, "hold");
    repeat (20) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("hold_count%0d", k), 32'(w_cnt[k]),  32'd2);
      check($sformatf("hold_busy%0d", k),  32'(w_busy[k]), 32'd0);
    end
    tx_enable = 1'b1;
    wait_idle(5000, 1'b1, "hold_drain");

    // write on the same edge as a pop with 5 queued
    tx_enable = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'($urandom));
    tick_auto    = 1'b0;
    tx_baud_tick = 1'b0;
    @(negedge clk);
    tx_enable    = 1'b1;
    tx_baud_tick = 1'b1;
    tx_valid     = 1'b1;
    tx_data      = 8'($urandom);
    @(negedge clk);
    tx_baud_tick = 1'b0;
    tx_valid     = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("wrpop_count%0d", k), 32'(w_cnt[k]),  32'd5);
      check($sformatf("wrpop_busy%0d", k),  32'(w_busy[k]), 32'd1);
    end
    tick_auto = 1'b1;
    wait_idle(8000, 1'b1, "wrpop_drain");

    // continuous random flow, wraps the pointers several times
    for (int i = 0; i < 400; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle(30000, 1'b1, "flow");

    // asynchronous reset mid-frame with words queued
    tx_enable = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    tx_enable = 1'b1;
    wait_bits_left(5, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("arst_pin%0d", k),   32'(w_pin[k]),   32'd1);
      check($sformatf("arst_busy%0d", k),  32'(w_busy[k]),  32'd0);
      check($sformatf("arst_ready%0d", k), 32'(w_ready[k]), 32'd1);
      check($sformatf("arst_count%0d", k), 32'(w_cnt[k]),   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_count", 32'(w_cnt[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
